// File: rtl/range_pkg.sv
// +----------------------------------------------------------------------+
// | range_pkg : shared constants, state encoding and width helper for    |
// |             the range-finder transmit/receive blocks                 |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

package range_pkg;

    localparam int c_DEFAULT_WIDTH = 8;
    localparam int c_DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Occupancy must represent the value DEPTH itself, hence the extra bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/range_burst_tx_if.sv
// +----------------------------------------------------------------------+
// | range_burst_tx_if : host-side load/start signals and go/finish       |
// |                     stream outputs of range_burst_tx                 |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface range_burst_tx_if
    import range_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int DEPTH = c_DEFAULT_DEPTH
);

    logic                      wr_en;
    logic [WIDTH-1:0]          wr_data;
    logic                      start;
    logic [WIDTH-1:0]          data_out;
    logic                      go;
    logic                      finish;
    logic                      busy;
    logic [cnt_w(DEPTH)-1:0]   count;
    logic [WIDTH-1:0]          exp_range;
    logic                      exp_valid;
    logic                      error;

    modport master (
        output wr_en, wr_data, start,
        input  data_out, go, finish, busy, count, exp_range, exp_valid, error
    );

    modport slave (
        input  wr_en, wr_data, start,
        output data_out, go, finish, busy, count, exp_range, exp_valid, error
    );

endinterface

`default_nettype wire

// File: rtl/range_tx_buf.sv
// +----------------------------------------------------------------------+
// | range_tx_buf : DEPTH x WIDTH word buffer with write/read pointers,   |
// |                occupancy count and synchronous clear                 |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module range_tx_buf
    import range_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int DEPTH = c_DEFAULT_DEPTH
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_data,
    input  wire logic                     i_pop,
    input  wire logic                     i_clear,
    output logic      [WIDTH-1:0]         o_rd_data,
    output logic      [$clog2(DEPTH):0]   o_count,
    output logic                          o_full,
    output logic                          o_empty
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Storage is deliberately not reset; only the bookkeeping is.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_full    = (r_count == c_CW'(DEPTH));
    assign o_empty   = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/range_burst_tx.sv
// +----------------------------------------------------------------------+
// | range_burst_tx : buffers host words and replays them as a go/finish  |
// |                  burst; optional max-min tracking (RANGE_TX_EXPECT_EN)|
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
`default_nettype none

module range_burst_tx
    import range_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int DEPTH = c_DEFAULT_DEPTH
) (
    input  wire logic        clock,
    input  wire logic        reset,
    range_burst_tx_if.slave  bus
);

    localparam int c_CW = cnt_w(DEPTH);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_first;
    logic             r_error;
    logic [c_CW-1:0]  w_count;
    logic [WIDTH-1:0] w_rd_data;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_last;
    logic             w_start_ok;
    logic             w_err_set;
    logic [WIDTH-1:0] w_data_out;
    logic             w_go;
    logic             w_finish;
    logic             w_busy;

    assign w_start_ok = bus.start && (r_state == IDLE) && (w_count >= c_CW'(2));
    assign w_push     = bus.wr_en && (r_state == IDLE) && !w_full && !bus.start;
    assign w_pop      = (r_state == SEND) && !w_empty;
    assign w_last     = w_pop && (w_count == c_CW'(1));
    assign w_err_set  = (bus.wr_en && !w_push) || (bus.start && !w_start_ok);

    range_tx_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clock),
        .rst       (reset),
        .i_push    (w_push),
        .i_data    (bus.wr_data),
        .i_pop     (w_pop),
        .i_clear   (w_last),
        .o_rd_data (w_rd_data),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_next_state = SEND;
            SEND:    if (w_last || w_empty) w_next_state = REPORT;
            REPORT:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_data_out = '0;
        w_go       = 1'b0;
        w_finish   = 1'b0;
        w_busy     = 1'b0;
        if (r_state == SEND) begin
            w_data_out = w_rd_data;
            w_go       = r_first;
            w_finish   = w_last;
            w_busy     = 1'b1;
        end
    end

    // r_first marks the cycle carrying word 0 of the current burst.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_first <= 1'b0;
            r_error <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_first <= 1'b1;
            end else if (r_state == SEND) begin
                r_first <= 1'b0;
            end
            // A dropped write alongside an accepted start still leaves error set.
            if (w_err_set) begin
                r_error <= 1'b1;
            end else if (w_start_ok) begin
                r_error <= 1'b0;
            end
        end
    end

    assign bus.data_out = w_data_out;
    assign bus.go       = w_go;
    assign bus.finish   = w_finish;
    assign bus.busy     = w_busy;
    assign bus.count    = w_count;
    assign bus.error    = r_error;

`ifdef RANGE_TX_EXPECT_EN
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_range;
    logic [WIDTH-1:0] w_max;
    logic [WIDTH-1:0] w_min;

    always_comb begin
        w_max = w_rd_data;
        w_min = w_rd_data;
        if (!r_first) begin
            if (r_max > w_rd_data) w_max = r_max;
            if (r_min < w_rd_data) w_min = r_min;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_max   <= '0;
            r_min   <= '0;
            r_range <= '0;
        end else if (w_pop) begin
            r_max <= w_max;
            r_min <= w_min;
            if (w_last) begin
                r_range <= w_max - w_min;
            end
        end
    end

    assign bus.exp_range = r_range;
    assign bus.exp_valid = (r_state == REPORT);
`else
    assign bus.exp_range = '0;
    assign bus.exp_valid = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_range_burst_tx.sv
// +----------------------------------------------------------------------+
// | tb_range_burst_tx : randomized scoreboard bench for range_burst_tx   |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_range_burst_tx;
    import range_pkg::*;

    localparam int W = 8;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    range_burst_tx_if #(.WIDTH(W), .DEPTH(D)) bus ();

    range_burst_tx #(.WIDTH(W), .DEPTH(D)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        int d;
        bit g;
        bit f;
        int c;
    } beat_t;

    beat_t sq[$];
    int    rq[$];
    int    mbuf[$];
    bit    merr;
    int    mbusy;
    int    m_range;
    int    cyc_n;
    int    total;
    int    bad;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
        end
    endfunction

    // One host cycle: apply inputs, update the reference model, advance, check.
    task automatic cycle(input bit wr, input int data, input bit st);
        bit idle;
        bit acc;
        bit wacc;
        bit eset;
        idle = (mbusy == 0);
        if (mbusy > 0) mbusy--;
        acc  = st && idle && (mbuf.size() >= 2);
        wacc = wr && idle && !st && (mbuf.size() < D);
        eset = (st && !acc) || (wr && !wacc);
        if (acc) begin
            int n;
            int mx;
            int mn;
            beat_t b;
            n  = mbuf.size();
            mx = mbuf[0];
            mn = mbuf[0];
            for (int i = 0; i < n; i++) begin
                b.d = mbuf[i];
                b.g = (i == 0);
                b.f = (i == n - 1);
                b.c = cyc_n + 1 + i;
                sq.push_back(b);
                if (mbuf[i] > mx) mx = mbuf[i];
                if (mbuf[i] < mn) mn = mbuf[i];
            end
`ifdef RANGE_TX_EXPECT_EN
            rq.push_back(mx - mn);
`endif
            mbusy = n + 1;
            mbuf.delete();
        end
        if (wacc) mbuf.push_back(data & 255);
        if (eset) merr = 1'b1;
        else if (acc) merr = 1'b0;

        bus.wr_en   = wr;
        bus.wr_data = W'(data);
        bus.start   = st;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        chk("error", bus.error, merr);
        if (mbusy == 0) chk("count", bus.count, mbuf.size());
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mbuf.delete();
        merr  = 1'b0;
        mbusy = 0;
        chk("rst_data_out",  bus.data_out,  0);
        chk("rst_go",        bus.go,        0);
        chk("rst_finish",    bus.finish,    0);
        chk("rst_busy",      bus.busy,      0);
        chk("rst_count",     bus.count,     0);
        chk("rst_exp_range", bus.exp_range, 0);
        chk("rst_exp_valid", bus.exp_valid, 0);
        chk("rst_error",     bus.error,     0);
    endtask

    task automatic burst4(input int a, input int b, input int c, input int d, input int n);
        if (n > 0) cycle(1'b1, a, 1'b0);
        if (n > 1) cycle(1'b1, b, 1'b0);
        if (n > 2) cycle(1'b1, c, 1'b0);
        if (n > 3) cycle(1'b1, d, 1'b0);
        cycle(1'b0, 0, 1'b1);
        idle_cycles(n + 3);
    endtask

    // Monitor: every cycle, pop expected beats while busy and check the report.
    initial begin : monitor
        bit    last_fin;
        beat_t b;
        last_fin = 1'b0;
        forever begin
            @(negedge clk);
            if (last_fin) begin
`ifdef RANGE_TX_EXPECT_EN
                chk("exp_valid_report", bus.exp_valid, 1);
                if (rq.size() > 0) begin
                    m_range = rq.pop_front();
                end else begin
                    total++;
                    bad++;
                    $display("FAIL range_queue: got empty want entry (t=%0t)", $time);
                end
`else
                chk("exp_valid_disabled", bus.exp_valid, 0);
`endif
            end else begin
                chk("exp_valid_quiet", bus.exp_valid, 0);
            end
            chk("exp_range", bus.exp_range, m_range);
            if (bus.busy) begin
                if (sq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_queue: got unexpected beat %0d want none (t=%0t)", bus.data_out, $time);
                end else begin
                    b = sq.pop_front();
                    chk("beat_data",   bus.data_out, b.d);
                    chk("beat_go",     bus.go,       b.g);
                    chk("beat_finish", bus.finish,   b.f);
                    chk("beat_cycle",  cyc_n,        b.c);
                end
            end else begin
                chk("idle_data_out", bus.data_out, 0);
                chk("idle_go",       bus.go,       0);
                chk("idle_finish",   bus.finish,   0);
            end
            last_fin = bus.busy && bus.finish;
            if (rst) begin
                sq.delete();
                rq.delete();
                m_range  = 0;
                last_fin = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        total       = 0;
        bad         = 0;
        cyc_n       = 0;
        m_range     = 0;
        merr        = 1'b0;
        mbusy       = 0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        do_reset();

        burst4(3, 9, 1, 7, 4);

        cycle(1'b1, 5, 1'b0);
        cycle(1'b0, 0, 1'b1);
        idle_cycles(2);
        burst4(5, 0, 0, 0, 1);

        for (int i = 0; i < 9; i++) cycle(1'b1, $urandom_range(0, 255), 1'b0);
        cycle(1'b0, 0, 1'b1);
        idle_cycles(11);

        for (int i = 0; i < 4; i++) cycle(1'b1, $urandom_range(0, 255), 1'b0);
        cycle(1'b0, 0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 'hAA, 1'(i % 2));
        idle_cycles(3);

        cycle(1'b1, 0, 1'b0);
        cycle(1'b1, 255, 1'b0);
        cycle(1'b1, 4, 1'b0);
        cycle(1'b0, 0, 1'b1);
        cycle(1'b0, 0, 1'b0);
        do_reset();
        idle_cycles(3);

        burst4(0, 255, 0, 0, 2);
        burst4(200, 200, 200, 0, 3);

        for (int it = 0; it < 40; it++) begin
            int n;
            int m;
            n = $urandom_range(0, 10);
            for (int i = 0; i < n; i++) cycle(1'b1, $urandom_range(0, 255), ($urandom_range(0, 15) == 0));
            cycle(($urandom_range(0, 3) == 0), $urandom_range(0, 255), 1'b1);
            m = $urandom_range(0, 12);
            for (int i = 0; i < m; i++) begin
                if ($urandom_range(0, 29) == 0) do_reset();
                else cycle(($urandom_range(0, 2) == 0), $urandom_range(0, 255), ($urandom_range(0, 5) == 0));
            end
            idle_cycles(12);
        end

        idle_cycles(4);
        chk("leftover_beats",  sq.size(), 0);
        chk("leftover_ranges", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/range_burst_tx.md
Name: range_burst_tx

Overview:
- Transmit side of the go/finish word-stream protocol consumed by the range-finder datapath.
- Host loads up to DEPTH words into an internal buffer, then pulses start.
- Block replays the buffered words one per cycle: go marks the first word, finish marks the last.
- Also produces the expected max-min range of the burst, so on-chip self-check needs no external model.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 8, buffer capacity in words; power of 2, at least 2.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- wr_en  input  1  push wr_data into the buffer.
- wr_data  input  WIDTH  word to buffer.
- start  input  1  single-cycle request to transmit the buffered burst.
- data_out  output  WIDTH  stream word; drives the receiver's data_in.
- go  output  1  high with the first word of a burst.
- finish  output  1  high with the last word of a burst.
- busy  output  1  high while a burst is in progress.
- count  output  $clog2(DEPTH)+1  number of words currently buffered.
- exp_range  output  WIDTH  expected max-min of the last burst.
- exp_valid  output  1  one-cycle strobe qualifying exp_range.
- error  output  1  sticky protocol-violation flag.

Behaviour:
- Single clock domain; synchronous active-high reset.
- Reset values: data_out=0, go=0, finish=0, busy=0, count=0, exp_range=0, exp_valid=0, error=0. Buffer contents are don't-care after reset.
- Reset mid-burst aborts the burst; the next cycle shows reset values; no finish is emitted.
- States:
  - IDLE: accepts writes.
  - SEND: emits words.
  - REPORT: single cycle; exp_valid=1.
  - Transitions: IDLE->SEND on an accepted start; SEND->REPORT after the finish word; REPORT->IDLE unconditionally.
- Writes:
  - Accepted only in IDLE with count<DEPTH and no start in the same cycle. count increments the next cycle.
  - Write while full is dropped and sets error.
  - Write while busy or in REPORT is dropped and sets error.
  - Write in the same cycle as an accepted start is dropped and sets error.
- Start:
  - Accepted in IDLE when count>=2.
  - Start with count<2 is ignored (stays IDLE, buffer kept) and sets error.
  - Start outside IDLE is ignored and sets error.
  - An accepted start clears error.
- Timing, with start sampled at edge T:
  - Word k (0-based) appears on data_out during cycle T+1+k.
  - go=1 only in cycle T+1; finish=1 only in cycle T+count.
  - go and finish are never high together.
  - busy is high from T+1 through T+count inclusive.
- Outside SEND: data_out=0, go=0, finish=0.
- After the finish cycle, count returns to 0; the buffer is consumed.
- Range tracking:
  - Running max and min are initialised from word 0 and updated unsigned per emitted word.
  - In the REPORT cycle (T+count+1): exp_range = max-min (WIDTH bits, never negative) and exp_valid=1.
  - exp_range holds until the next REPORT or reset.
- Equal words give exp_range=0.
- Full-scale extremes 0 and 2^WIDTH-1 give exp_range=2^WIDTH-1 with no wrap.

Optional Feature:
- Macro RANGE_TX_EXPECT_EN.
- Defined: running max/min registers and the exp_range/exp_valid behaviour above.
- Undefined: tracking logic removed; exp_range tied to 0 and exp_valid tied to 0. The REPORT state is still traversed, so burst timing is identical.

Decomposition:
- Shared package range_pkg holds:
  - default WIDTH and DEPTH constants;
  - state enum typedef (IDLE, SEND, REPORT), shared with the range-finder bench;
  - count width derived by a localparam function.
- One sub-module, range_tx_buf: DEPTH x WIDTH register array with write pointer, read pointer and count; push/pop/clear inputs; full/empty outputs.
- FSM and range tracking stay in range_burst_tx.

Test Plan:
- Basic burst: push 3,9,1,7; start -> go+3, then 9, then 1, then finish+7 on consecutive cycles; exp_valid with exp_range=8 the next cycle; count=0 afterwards.
- Short burst: push 5 only; start -> no go, error=1, count stays 1. Then push 5 and start -> burst 5,5 with exp_range=0 and error cleared.
- Overflow (DEPTH=8): push 9 words -> 9th dropped, error=1, count=8. Start -> 8 words, go on the first, finish on the 8th.
- Writes and start during busy: wr_en=1 (wr_data=0xAA) and a second start during SEND -> burst unchanged, 0xAA never transmitted, error=1.
- Reset mid-burst: push 0,255,4; start; assert reset on the 2nd word -> next cycle all outputs zero, no finish, no exp_valid.
- Extremes: burst 0,255 -> exp_range=255. With RANGE_TX_EXPECT_EN undefined -> exp_valid never asserts, stream timing identical.
